// File: rtl/serial_to_parallel_sync.sv
// Receive-side deserializer: hunts for COM bit-by-bit, confirms byte alignment over
// SYNC_COMS consecutive COMs, then delivers registered bytes with valid and strobe.
module serial_to_parallel_sync #(
  parameter logic [7:0]  COM       = 8'hBC,
  parameter logic [7:0]  IDLE      = 8'h7C,
  parameter int unsigned SYNC_COMS = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_stb,
  output logic       active
);

  typedef enum logic [1:0] {
    S_HUNT   = 2'd0,
    S_ALIGN  = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  localparam logic [3:0] SYNC_W = SYNC_COMS[3:0];

  state_t     r_state;
  state_t     w_state_nxt;
  logic [6:0] r_sr;
  logic [2:0] r_bit_cnt;
  logic [2:0] w_bit_cnt_nxt;
  logic [3:0] r_com_cnt;
  logic [3:0] w_com_cnt_nxt;
  logic [7:0] r_data;
  logic       r_valid;
  logic       r_stb;

  logic [7:0] w_nb;
  logic       w_is_com;
  logic       w_boundary;
  logic       w_stb_nxt;
  logic       w_load;
  logic       w_valid_nxt;

  // Only the low seven bits of the shift history are ever read back, so only those are stored.
  assign w_nb       = {r_sr, serial_in};
  assign w_is_com   = (w_nb == COM);
  assign w_boundary = (r_bit_cnt == 3'd7);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      r_sr <= 7'd0;
    end else begin
      r_sr <= w_nb[6:0];
    end
  end

  // NOTE: reset is synchronous; it is only seen at a clock edge and overrides every other update.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      r_state   <= S_HUNT;
      r_bit_cnt <= 3'd0;
      r_com_cnt <= 4'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_com_cnt <= w_com_cnt_nxt;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_com_cnt_nxt = r_com_cnt;
    unique case (r_state)
      S_HUNT: begin
        w_bit_cnt_nxt = 3'd0;
        if (w_is_com) begin
          w_com_cnt_nxt = 4'd1;
          w_state_nxt   = (SYNC_W == 4'd1) ? S_ACTIVE : S_ALIGN;
        end
      end
      S_ALIGN: begin
        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
        if (w_boundary) begin
          if (w_is_com) begin
            w_com_cnt_nxt = r_com_cnt + 4'd1;
            if ((r_com_cnt + 4'd1) == SYNC_W) begin
              w_state_nxt = S_ACTIVE;
            end
          end else begin
            // Misaligned or corrupted comma: drop lock and rescan from the next bit.
            w_com_cnt_nxt = 4'd0;
            w_bit_cnt_nxt = 3'd0;
            w_state_nxt   = S_HUNT;
          end
        end
      end
      S_ACTIVE: begin
        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
      end
      default: begin
        w_state_nxt   = S_HUNT;
        w_bit_cnt_nxt = 3'd0;
        w_com_cnt_nxt = 4'd0;
      end
    endcase
  end

  always_comb begin
    w_stb_nxt   = w_boundary && (r_state != S_HUNT);
    w_load      = w_boundary && (r_state == S_ACTIVE);
    w_valid_nxt = !w_is_com && (w_nb != IDLE);
    active      = (r_state == S_ACTIVE);
  end

  // Byte outputs update on the edge that samples a byte's last bit and hold for the slot.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      r_data  <= 8'd0;
      r_valid <= 1'b0;
      r_stb   <= 1'b0;
    end else begin
      r_stb <= w_stb_nxt;
      if (w_load) begin
        r_data  <= w_nb;
        r_valid <= w_valid_nxt;
      end
    end
  end

  assign data_out  = r_data;
  assign valid_out = r_valid;
  assign byte_stb  = r_stb;

endmodule

// File: tb/tb_serial_to_parallel_sync.sv
// Bench for serial_to_parallel_sync: byte-level vector table, directed corner sequences and
// random traffic, all compared every cycle against a byte/bit-count reference model.
module tb_serial_to_parallel_sync;

  localparam logic [7:0] COM  = 8'hBC;
  localparam logic [7:0] IDLE = 8'h7C;

  logic       clk_32f;
  logic       reset;
  logic       serial_in;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b;
  logic       stb_a, stb_b;
  logic       active_a, active_b;

  int n_vec;
  int n_err;

  serial_to_parallel_sync #(.COM(COM), .IDLE(IDLE), .SYNC_COMS(4)) dut (
    .clk_32f  (clk_32f),
    .reset    (reset),
    .serial_in(serial_in),
    .data_out (data_a),
    .valid_out(valid_a),
    .byte_stb (stb_a),
    .active   (active_a)
  );

  serial_to_parallel_sync #(.COM(COM), .IDLE(IDLE), .SYNC_COMS(1)) dut1 (
    .clk_32f  (clk_32f),
    .reset    (reset),
    .serial_in(serial_in),
    .data_out (data_b),
    .valid_out(valid_b),
    .byte_stb (stb_b),
    .active   (active_b)
  );

  initial clk_32f = 1'b0;
  always #5 clk_32f = ~clk_32f;

  // Reference model: mode 0=hunting, 1=counting commas, 2=link up; nbits counts bits since lock.
  int         sync_k [2];
  logic [7:0] m_win  [2];
  int         m_mode [2];
  int         m_nbits[2];
  int         m_run  [2];
  logic [7:0] m_data [2];
  logic       m_valid[2];
  logic       m_stb  [2];

  task automatic model_step(input int k, input logic rst, input logic b);
    logic [7:0] w;
    w = {m_win[k][6:0], b};
    if (rst) begin
      m_win[k] = 8'd0; m_mode[k] = 0; m_nbits[k] = 0; m_run[k] = 0;
      m_data[k] = 8'd0; m_valid[k] = 1'b0; m_stb[k] = 1'b0;
    end else begin
      m_win[k] = w;
      m_stb[k] = 1'b0;
      case (m_mode[k])
        0: if (w == COM) begin
          m_run[k]   = 1;
          m_nbits[k] = 0;
          m_mode[k]  = (sync_k[k] == 1) ? 2 : 1;
        end
        1: begin
          m_nbits[k]++;
          if (m_nbits[k] % 8 == 0) begin
            m_stb[k] = 1'b1;
            if (w == COM) begin
              m_run[k]++;
              if (m_run[k] == sync_k[k]) m_mode[k] = 2;
            end else begin
              m_mode[k] = 0;
              m_run[k]  = 0;
            end
          end
        end
        default: begin
          m_nbits[k]++;
          if (m_nbits[k] % 8 == 0) begin
            m_stb[k]   = 1'b1;
            m_data[k]  = w;
            m_valid[k] = (w != COM) && (w != IDLE);
          end
        end
      endcase
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One bit slot: drive at negedge, step the model, sample both DUTs 1 ns after the edge.
  task automatic cycle(input logic rst, input logic b);
    @(negedge clk_32f);
    reset     = rst;
    serial_in = b;
    model_step(0, rst, b);
    model_step(1, rst, b);
    @(posedge clk_32f);
    #1;
    check("sync4 cycle {data,valid,stb,active}", {data_a, valid_a, stb_a, active_a},
          {m_data[0], m_valid[0], m_stb[0], m_mode[0] == 2});
    check("sync1 cycle {data,valid,stb,active}", {data_b, valid_b, stb_b, active_b},
          {m_data[1], m_valid[1], m_stb[1], m_mode[1] == 2});
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) cycle(1'b0, v[i]);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
  endtask

  typedef struct {
    logic [7:0] byte_v;
    logic [7:0] exp_data;
    logic       exp_valid;
    logic       exp_stb;
    logic       exp_active;
  } vec_t;

  vec_t tbl[9];

  initial begin
    n_vec = 0;
    n_err = 0;
    sync_k[0] = 4;
    sync_k[1] = 1;
    reset     = 1'b1;
    serial_in = 1'b0;

    // Lock, data, then idle/comma/data while up; expectations for the SYNC_COMS=4 instance.
    tbl[0] = '{8'hBC, 8'h00, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{8'hBC, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{8'hBC, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{8'hBC, 8'h00, 1'b0, 1'b1, 1'b1};
    tbl[4] = '{8'hA5, 8'hA5, 1'b1, 1'b1, 1'b1};
    tbl[5] = '{8'h3C, 8'h3C, 1'b1, 1'b1, 1'b1};
    tbl[6] = '{8'h7C, 8'h7C, 1'b0, 1'b1, 1'b1};
    tbl[7] = '{8'hBC, 8'hBC, 1'b0, 1'b1, 1'b1};
    tbl[8] = '{8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1};

    do_reset();
    check("reset outputs", {data_a, valid_a, stb_a, active_a}, 11'd0);
    for (int i = 0; i < 9; i++) begin
      send_byte(tbl[i].byte_v);
      check($sformatf("table[%0d]", i), {data_a, valid_a, stb_a, active_a},
            {tbl[i].exp_data, tbl[i].exp_valid, tbl[i].exp_stb, tbl[i].exp_active});
    end

    // Lock at bit offset 3.
    do_reset();
    cycle(1'b0, 1'b1); cycle(1'b0, 1'b0); cycle(1'b0, 1'b1);
    repeat (4) send_byte(COM);
    check("offset3 active", active_a, 1'b1);
    send_byte(8'h11);
    check("offset3 data", {data_a, valid_a}, {8'h11, 1'b1});

    // Broken comma run falls back, second run locks.
    do_reset();
    repeat (3) send_byte(COM);
    send_byte(8'h55);
    check("fallback active", {stb_a, active_a}, 2'b10);
    repeat (3) send_byte(COM);
    check("relock not yet", active_a, 1'b0);
    send_byte(COM);
    check("relock active", active_a, 1'b1);

    // Reset mid-byte while up.
    send_byte(8'h42);
    cycle(1'b0, 1'b1); cycle(1'b0, 1'b0); cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b1);
    check("midbyte reset", {data_a, valid_a, stb_a, active_a}, 11'd0);
    repeat (3) send_byte(COM);
    check("post reset 3 coms", active_a, 1'b0);
    send_byte(COM);
    check("post reset 4 coms", active_a, 1'b1);

    // Single-comma lock instance.
    do_reset();
    send_byte(COM);
    check("sync1 active", {active_b, active_a}, 2'b10);
    send_byte(8'h5A);
    check("sync1 data", {data_b, valid_b, stb_b}, {8'h5A, 1'b1, 1'b1});

    // Random traffic: comma runs, data, misaligning bit slips, rare resets.
    for (int n = 0; n < 300; n++) begin
      int r;
      r = int'($urandom_range(0, 19));
      if (r < 8)       send_byte(COM);
      else if (r < 10) send_byte(IDLE);
      else if (r < 17) send_byte(8'($urandom));
      else if (r < 19) repeat ($urandom_range(1, 7)) cycle(1'b0, 1'($urandom));
      else             cycle(1'b1, 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
